bcd_digit_sequencer: RTL and testbench

Downstream consumer of the repeated-subtraction divide-by-10 datapath/controller pair. It takes a 16-bit binary value and drives the divider once per decimal digit, feeding each quotient back as the next dividend and collecting each remainder as a BCD digit. The result is a 5-digit packed BCD word for the display stage. It also runs a watchdog so that a hung divider cannot stall the display path.

---
 rtl/bcd_digit_sequencer_pkg.sv | 20 ++
 rtl/bcd_digit_sequencer_watchdog.sv | 27 ++
 rtl/bcd_digit_sequencer.sv | 132 +++++++++++++
 tb/tb_bcd_digit_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_digit_sequencer_pkg.sv
// rtl/bcd_digit_sequencer_pkg.sv - shared types and constants for the BCD digit sequencer
package bcd_digit_sequencer_pkg;

  localparam int NDIG        = 5;
  localparam int DIG_W       = 4;
  localparam int DATA_W      = 16;
  localparam int BCD_W       = NDIG * DIG_W;
  localparam int TIMEOUT_DEF = 8192;

  localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    STORE,
    FIN
  } state_t;

endpackage

// File: rtl/bcd_digit_sequencer_watchdog.sv
// rtl/bcd_digit_sequencer_watchdog.sv - saturating cycle counter with clear and expire
module bcd_watchdog #(
  parameter int LIMIT = 8192,
  parameter int W     = $clog2(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  // count enabled cycles since the last clear, holding at LAST instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/bcd_digit_sequencer.sv
// rtl/bcd_digit_sequencer.sv - drives a divide-by-10 unit once per digit to build packed BCD
module bcd_digit_sequencer
  import bcd_digit_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin_in,
  output logic              div_start,
  output logic [DATA_W-1:0] div_data,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quot,
  input  logic [DIG_W-1:0]  div_rem,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output logic [2:0]        ndigits,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] cur;
  logic [2:0]        idx;
  logic [WD_W-1:0]   wd_count;
  logic              wd_expire;
  logic              first_wait;
  logic              rem_bad;
  logic              quot_zero;
  logic              last_dig;

  bcd_watchdog #(
    .LIMIT (TIMEOUT),
    .W     (WD_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ISSUE),
    .en     (state == WAIT),
    .count  (wd_count),
    .expire (wd_expire)
  );

  // the watchdog is cleared in ISSUE, so a zero count marks the divider's deassert window
  assign first_wait = (wd_count == '0);
  assign rem_bad    = (div_rem > BCD_MAX);
  assign quot_zero  = (div_quot == '0);
  assign last_dig   = (idx == 3'(NDIG - 1));
  assign div_data   = cur;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (!first_wait && div_done) begin
          state_nxt = STORE;
        end else if (wd_expire) begin
          state_nxt = FIN;
        end
      end
      STORE:   state_nxt = (rem_bad || quot_zero || last_dig) ? FIN : ISSUE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded handshake outputs
  always_comb begin
    div_start = (state == ISSUE);
    busy      = (state != IDLE);
  end

  // operand, digit collection and registered result/status
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      idx     <= '0;
      bcd     <= '0;
      ndigits <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state_nxt == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            cur     <= bin_in;
            idx     <= '0;
            bcd     <= '0;
            ndigits <= '0;
            err     <= 1'b0;
          end
        end
        WAIT: begin
          if (state_nxt == FIN) err <= 1'b1;
        end
        STORE: begin
          if (rem_bad) begin
            err <= 1'b1;
          end else begin
            for (int i = 0; i < NDIG; i++) begin
              if (idx == 3'(i)) bcd[i*DIG_W +: DIG_W] <= div_rem;
            end
            idx     <= idx + 3'd1;
            ndigits <= idx + 3'd1;
            cur     <= div_quot;
            // a fifth digit with quotient left over means the value did not fit
            if (last_dig && !quot_zero) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// tb/tb_bcd_digit_sequencer.sv - scoreboard bench for bcd_digit_sequencer
module tb_bcd_digit_sequencer;
  import bcd_digit_sequencer_pkg::*;

  localparam int TO     = 8192;
  localparam int M_NORM = 0;
  localparam int M_HANG = 1;
  localparam int M_BAD  = 2;

  typedef struct packed {
    logic [19:0] bcd;
    logic [2:0]  nd;
    logic        err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        div_start;
  logic [15:0] div_data;
  logic        div_done = 1'b0;
  logic [15:0] div_quot = '0;
  logic [3:0]  div_rem = '0;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [2:0]  ndigits;
  logic        err;

  logic [15:0] exp_div[$];
  res_t        exp_res[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ds_cnt = 0;
  int t_start = 0;
  int mode = M_NORM;
  int dlat = 3;
  bit chk_zero = 1'b0;
  bit chk_empty = 1'b0;
  bit to_flag = 1'b0;

  always #5 clk = ~clk;

  bcd_digit_sequencer #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin_in    (bin_in),
    .div_start (div_start),
    .div_data  (div_data),
    .div_done  (div_done),
    .div_quot  (div_quot),
    .div_rem   (div_rem),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .ndigits   (ndigits),
    .err       (err)
  );

  // divider model plus monitor/scoreboard, all sampled on the falling edge
  initial begin : monitor
    logic [15:0] e;
    logic [15:0] dv_val;
    int          dv_cnt;
    bit          dv_active;
    res_t        r;
    dv_val = '0;
    dv_cnt = 0;
    dv_active = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        div_done = 1'b0;
        dv_active = 1'b0;
      end else if (div_start) begin
        n_checks++;
        if (exp_div.size() == 0) begin
          n_fail++;
          $display("FAIL div_start_extra: got divide of %0d, required none", div_data);
        end else begin
          e = exp_div.pop_front();
          if (div_data !== e) begin
            n_fail++;
            $display("FAIL div_data: got %0d, required %0d", div_data, e);
          end
        end
        dv_val = div_data;
        dv_cnt = 0;
        dv_active = 1'b1;
        div_done = 1'b0;
        t_start = cyc;
        ds_cnt++;
      end else if (dv_active && mode != M_HANG) begin
        dv_cnt++;
        if (dv_cnt == dlat) begin
          div_done = 1'b1;
          div_quot = dv_val / 16'd10;
          div_rem = (mode == M_BAD) ? 4'd12 : 4'(dv_val % 16'd10);
          dv_active = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        dv_active = 1'b0;
        n_checks++;
        if (exp_res.size() == 0) begin
          n_fail++;
          $display("FAIL done_extra: got done pulse, required none");
        end else begin
          r = exp_res.pop_front();
          if (bcd !== r.bcd) begin
            n_fail++;
            $display("FAIL bcd: got %05h, required %05h", bcd, r.bcd);
          end
          n_checks++;
          if (ndigits !== r.nd) begin
            n_fail++;
            $display("FAIL ndigits: got %0d, required %0d", ndigits, r.nd);
          end
          n_checks++;
          if (err !== r.err) begin
            n_fail++;
            $display("FAIL err: got %0b, required %0b", err, r.err);
          end
          n_checks++;
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_at_done: got %0b, required 1", busy);
          end
          if (mode == M_HANG) begin
            n_checks++;
            if (cyc != t_start + 1 + TO) begin
              n_fail++;
              $display("FAIL timeout_cycle: got %0d cycles after first WAIT, required %0d",
                       cyc - t_start - 1, TO);
            end
          end
        end
      end
      if (chk_zero) begin
        n_checks++;
        if ({div_start, busy, done, err, bcd, ndigits, div_data} !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got ds=%0b busy=%0b done=%0b err=%0b bcd=%05h nd=%0d dd=%0d, required all 0",
                   div_start, busy, done, err, bcd, ndigits, div_data);
        end
      end
      if (chk_empty) begin
        n_checks++;
        if (exp_div.size() != 0 || exp_res.size() != 0) begin
          n_fail++;
          $display("FAIL divide_count: got %0d divides and %0d results outstanding, required 0",
                   exp_div.size(), exp_res.size());
        end
      end
      if (to_flag) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_done: got no done within budget, required done");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: digits by repeated /10 and %10 on the whole value
  task automatic model_push(input logic [15:0] v, input int m);
    logic [15:0] x;
    res_t        r;
    int          n;
    x = v;
    r = '0;
    n = 0;
    if (m != M_NORM) begin
      exp_div.push_back(v);
      r.err = 1'b1;
      exp_res.push_back(r);
      return;
    end
    do begin
      exp_div.push_back(x);
      r.bcd = r.bcd | (20'(x % 16'd10) << (4 * n));
      n++;
      x = x / 16'd10;
    end while (x != 0 && n < NDIG);
    r.nd = 3'(n);
    exp_res.push_back(r);
  endtask

  task automatic wait_done(input int base, input int budget);
    int b;
    b = budget;
    while (done_cnt == base && b > 0) begin
      tick();
      b--;
    end
    if (done_cnt == base) begin
      to_flag = 1'b1;
      tick();
      to_flag = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_div.delete();
      exp_res.delete();
    end
    tick();
  endtask

  task automatic run(input logic [15:0] v, input int m, input int lat, input bit extra,
                     input int budget);
    int base;
    base = done_cnt;
    mode = m;
    dlat = lat;
    model_push(v, m);
    bin_in = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin_in = 16'($urandom);
    if (extra) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done(base, budget);
    chk_empty = 1'b1;
    tick();
    chk_empty = 1'b0;
  endtask

  initial begin : stim
    int b;
    int base_ds;
    logic [15:0] v;
    repeat (3) tick();
    chk_zero = 1'b1;
    tick();
    chk_zero = 1'b0;
    rst = 1'b0;
    tick();

    run(16'd0, M_NORM, 3, 1'b0, 200);
    run(16'd12345, M_NORM, 4, 1'b0, 500);
    run(16'd907, M_NORM, 2, 1'b1, 500);
    run(16'd65535, M_NORM, 6555, 1'b0, 40000);
    run(16'd4321, M_HANG, 3, 1'b0, TO + 200);
    run(16'd5, M_NORM, 3, 1'b0, 200);
    run(16'd777, M_BAD, 3, 1'b0, 200);

    // reset during the third WAIT of 12345
    base_ds = ds_cnt;
    mode = M_NORM;
    dlat = 5;
    model_push(16'd12345, M_NORM);
    bin_in = 16'd12345;
    start = 1'b1;
    tick();
    start = 1'b0;
    b = 300;
    while (ds_cnt < base_ds + 3 && b > 0) begin
      tick();
      b--;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero = 1'b1;
    exp_div.delete();
    exp_res.delete();
    tick();
    chk_zero = 1'b0;
    run(16'd42, M_NORM, 3, 1'b0, 200);

    for (int i = 0; i < 10; i++) begin
      v = (i % 2 == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom_range(0, 65535));
      run(v, M_NORM, $urandom_range(2, 6), 1'b0, 2000);
    end

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
